serial_nibble_rx: RTL and testbench



---
 rtl/serial_pkg.sv | 26 ++
 rtl/serial_bit_counter.sv | 30 +++
 rtl/serial_nibble_rx.sv | 122 ++++++++++++
 tb/tb_serial_nibble_rx.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the framed serial receiver.
// The optional parity bit is enabled with the SERIAL_RX_PARITY_EN macro.
package serial_pkg;

  // State encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StData   = ST_DATA,
    StParity = ST_PARITY,
    StStop   = ST_STOP
  } rx_state_e;

  // Level of the serial line when nothing is being sent
  localparam logic LINE_IDLE = 1'b1;

  // Bits per frame: start + data + optional parity + stop
  function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
    return width + 32'd2 + (parity_en ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Data-bit counter for the serial receiver: clear, enable and terminal count.
module serial_bit_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] cnt_q;

  // Count sampled data bits; clear wins over enable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // High while the last data bit of the frame is being sampled
  assign tc_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_nibble_rx.sv
// Framed serial receiver: start bit, WIDTH data bits MSB first, optional
// parity bit, stop bit. Define SERIAL_RX_PARITY_EN to add the parity bit.
module serial_nibble_rx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             bit_en,
  input  logic             SerialIn,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_err,
  output logic             par_err,
  output logic             busy
);

  // Reject unsupported configurations at elaboration
  if (WIDTH < 2 || WIDTH > 16 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("serial_nibble_rx: WIDTH must be 2..16 and PARITY_ODD 0 or 1");
  end

  rx_state_e        state_q;
  logic [WIDTH-1:0] shift_q;
  logic             last_bit;

`ifdef SERIAL_RX_PARITY_EN
  logic par_bad_q;
`endif

  serial_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk_i  (CLK),
    .rst_ni (RST),
    .clr_i  (state_q == StIdle),
    .en_i   (bit_en && (state_q == StData)),
    .tc_o   (last_bit)
  );

`ifndef SERIAL_RX_PARITY_EN
  assign par_err = 1'b0;
`endif

  // Frame FSM with shift path and registered outputs; pulses self-clear every edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q <= 1'b0;
      par_err   <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
      if (bit_en) begin
        unique case (state_q)
          StIdle: begin
            if (SerialIn != LINE_IDLE) begin
              state_q <= StData;
              busy    <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
              par_bad_q <= 1'b0;
`endif
            end
          end
          StData: begin
            shift_q <= {shift_q[WIDTH-2:0], SerialIn};
            if (last_bit) begin
`ifdef SERIAL_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end
`ifdef SERIAL_RX_PARITY_EN
          StParity: begin
            par_bad_q <= ((^shift_q) ^ SerialIn) != PARITY_ODD[0];
            state_q   <= StStop;
          end
`endif
          StStop: begin
            state_q <= StIdle;
            busy    <= 1'b0;
            if (SerialIn == LINE_IDLE) begin
`ifdef SERIAL_RX_PARITY_EN
              if (par_bad_q) begin
                par_err <= 1'b1;
              end else begin
                data  <= shift_q;
                valid <= 1'b1;
              end
`else
              data  <= shift_q;
              valid <= 1'b1;
`endif
            end else begin
              // A bad stop bit hides any parity mismatch
              frame_err <= 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Self-checking bench for serial_nibble_rx; frames are built from words and
// the expected outputs follow from the framing rules.
module tb_serial_nibble_rx;
  import serial_pkg::*;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned PARITY_ODD = 0;
`ifdef SERIAL_RX_PARITY_EN
  localparam bit ParOn = 1'b1;
`else
  localparam bit ParOn = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic             bit_en;
  logic             SerialIn;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             frame_err;
  logic             par_err;
  logic             busy;

  int               checks   = 0;
  int               failures = 0;
  logic [WIDTH-1:0] model_data;

  serial_nibble_rx #(
    .WIDTH      (WIDTH),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bit_en    (bit_en),
    .SerialIn  (SerialIn),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .par_err   (par_err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit eb, input bit ev, input bit ef,
                           input bit ep);
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(ef));
    chk({tag, ".par_err"}, 32'(par_err), 32'(ep));
    chk({tag, ".data"}, 32'(data), 32'(model_data));
  endtask

  // Drive inputs on the falling edge, sample 1 ns after the rising edge
  task automatic edge_drive(input logic b, input logic en);
    @(negedge CLK);
    SerialIn = b;
    bit_en   = en;
    @(posedge CLK);
    #1;
  endtask

  // One strobed bit followed by gap cycles with bit_en low
  task automatic strobe(input string tag, input logic b, input int gap, input bit eb,
                        input bit ev, input bit ef, input bit ep);
    edge_drive(b, 1'b1);
    check_out(tag, eb, ev, ef, ep);
    for (int g = 0; g < gap; g++) begin
      edge_drive(1'($urandom), 1'b0);
      check_out({tag, ".hold"}, eb, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input string tag, input logic [WIDTH-1:0] w, input logic stop_bit,
                            input bit flip, input int gap);
    bit ev, ef, ep;
    strobe({tag, ".start"}, 1'b0, gap, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      strobe({tag, ".d"}, w[i], gap, 1'b1, 1'b0, 1'b0, 1'b0);
    end
`ifdef SERIAL_RX_PARITY_EN
    strobe({tag, ".par"}, (^w) ^ PARITY_ODD[0] ^ flip, gap, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    ef = !stop_bit;
    ep = stop_bit && flip && ParOn;
    ev = stop_bit && !ep;
    if (ev) model_data = w;
    strobe({tag, ".stop"}, stop_bit, gap, 1'b0, ev, ef, ep);
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    RST        = 1'b0;
    bit_en     = 1'b0;
    SerialIn   = 1'b1;
    model_data = '0;
    #1;
    check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // Idle line
    for (int i = 0; i < 20; i++) strobe("idle", 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load a word, then abandon a frame with reset
    send_frame("pre", 4'b0110, 1'b1, 1'b0, 0);
    strobe("mid.start", 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    strobe("mid.d1", 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    strobe("mid.d0", 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    RST      = 1'b0;
    SerialIn = 1'b1;
    bit_en   = 1'b0;
    model_data = '0;
    #1;
    check_out("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    RST = 1'b1;
    send_frame("after_rst", 4'b1011, 1'b1, 1'b0, 0);

    // Back-to-back frames, no idle gap
    send_frame("b2b1", 4'b1001, 1'b1, 1'b0, 0);
    send_frame("b2b2", 4'b0110, 1'b1, 1'b0, 0);

    // Bad stop bit keeps the previous word
    send_frame("badstop", 4'b1111, 1'b0, 1'b0, 0);
    strobe("after_bad", 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // bit_en high one cycle in four
    send_frame("throttle", 4'b0011, 1'b1, 1'b0, 3);

`ifdef SERIAL_RX_PARITY_EN
    send_frame("par_ok", 4'b1011, 1'b1, 1'b0, 0);
    send_frame("par_bad", 4'b0100, 1'b1, 1'b1, 0);
    send_frame("par_and_stop", 4'b0001, 1'b0, 1'b1, 0);
`endif

    // Random frames with random gaps, idle bits and errors
    for (int n = 0; n < 40; n++) begin
      int idle;
      w    = WIDTH'($urandom);
      idle = int'($urandom_range(0, 2));
      for (int k = 0; k < idle; k++) strobe("rnd.idle", 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame("rnd", w, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
